// File: rtl/cc_pkg.sv
// Shared cache-controller types and line geometry.
package cc_pkg;
  localparam int DATA_W = 64;
  localparam int BEATS  = 8;
  localparam int LINE_W = DATA_W * BEATS;
  localparam int IDX_W  = $clog2(BEATS);

  // Index of an 8-byte word within a line (addr[5:3]).
  typedef logic [IDX_W-1:0] word_off_t;

  typedef enum logic {IDLE, SEND} ser_state_e;
endpackage

// File: rtl/cc_serializer_if.sv
// Line-load handshake plus upstream AXI R channel of the serializer.
interface cc_serializer_if;
  import cc_pkg::*;

  logic              line_valid_i;
  logic              line_ready_o;
  logic [LINE_W-1:0] line_data_i;
  word_off_t         line_offset_i;
  logic [DATA_W-1:0] inct_rdata_o;
  logic [1:0]        inct_rresp_o;
  logic              inct_rlast_o;
  logic              inct_rvalid_o;
  logic              inct_rready_i;

  // Serializer side.
  modport slave (
    input  line_valid_i, line_data_i, line_offset_i, inct_rready_i,
    output line_ready_o, inct_rdata_o, inct_rresp_o, inct_rlast_o, inct_rvalid_o
  );

  // Line source / R consumer side.
  modport master (
    output line_valid_i, line_data_i, line_offset_i, inct_rready_i,
    input  line_ready_o, inct_rdata_o, inct_rresp_o, inct_rlast_o, inct_rvalid_o
  );
endinterface

// File: rtl/cc_beat_mux.sv
// Selects one DATA_W word out of a packed line; shared with the fill path.
module cc_beat_mux #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 8
) (
  input  logic [DATA_W*BEATS-1:0]  line,
  input  logic [$clog2(BEATS)-1:0] idx,
  output logic [DATA_W-1:0]        word
);
  logic [BEATS-1:0][DATA_W-1:0] words;

  assign words = line;
  assign word  = words[idx];
endmodule

// File: rtl/cc_serializer.sv
// Line-to-R-burst serializer: wrapping, critical-word-first, back-to-back capable.
module cc_serializer
  import cc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  cc_serializer_if.slave s
);
  localparam word_off_t LAST_IDX = word_off_t'(BEATS - 1);
  localparam word_off_t PEN_IDX  = word_off_t'(BEATS - 2);
  localparam word_off_t ONE      = word_off_t'(1);

  ser_state_e        state;
  logic [LINE_W-1:0] buf_q;
  word_off_t         off_q;
  word_off_t         beat_cnt;
  logic              rvalid_q;
  logic              rlast_q;

  word_off_t         idx;
  logic              beat_done;

  // Wrap is free: the index is IDX_W bits wide.
  assign idx       = off_q + beat_cnt;
  assign beat_done = rvalid_q & s.inct_rready_i;

  // Ready in SEND only on the final handshake so the next line follows with no gap.
  assign s.line_ready_o  = (state == IDLE) | (rlast_q & s.inct_rready_i);
  assign s.inct_rvalid_o = rvalid_q;
  assign s.inct_rlast_o  = rlast_q;
  assign s.inct_rresp_o  = 2'b00;

  cc_beat_mux #(.DATA_W(DATA_W), .BEATS(BEATS)) u_mux (
    .line (buf_q),
    .idx  (idx),
    .word (s.inct_rdata_o)
  );

  // Burst FSM: loads the line, steps the beat counter, registers valid/last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      buf_q    <= '0;
      off_q    <= '0;
      beat_cnt <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s.line_valid_i) begin
            buf_q    <= s.line_data_i;
            off_q    <= s.line_offset_i;
            beat_cnt <= '0;
            rvalid_q <= 1'b1;
            rlast_q  <= (LAST_IDX == '0);
            state    <= SEND;
          end
        end
        SEND: begin
          if (beat_done) begin
            if (rlast_q) begin
              if (s.line_valid_i) begin
                buf_q    <= s.line_data_i;
                off_q    <= s.line_offset_i;
                beat_cnt <= '0;
                rlast_q  <= (LAST_IDX == '0);
              end else begin
                beat_cnt <= '0;
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              beat_cnt <= beat_cnt + ONE;
              rlast_q  <= (beat_cnt == PEN_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cc_serializer.sv
// Directed bench for cc_serializer: wrap order, stalls, back-to-back, mid-burst load and reset.
module tb_cc_serializer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_run  = 0;
  int   n_fail = 0;

  cc_serializer_if bus();

  cc_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base | 64'(k);
    return l;
  endfunction

  function automatic logic [63:0] wexp(input logic [63:0] base, input logic [2:0] w);
    return base | {61'd0, w};
  endfunction

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_run++;
    if (bus.inct_rvalid_o !== 1'b0 || bus.inct_rlast_o !== 1'b0 ||
        bus.inct_rdata_o !== 64'd0 || bus.line_ready_o !== 1'b1 || bus.inct_rresp_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset: rvalid=%b rlast=%b rdata=%h ready=%b rresp=%b, want 0 0 0 1 00",
               bus.inct_rvalid_o, bus.inct_rlast_o, bus.inct_rdata_o, bus.line_ready_o, bus.inct_rresp_o);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    logic [2:0]  offs [2];
    logic [63:0] base;
    logic [2:0]  w;
    logic        el;
    offs[0] = 3'd0; offs[1] = 3'd5;
    base = 64'h1111_0000_0000_0000;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      bus.line_valid_i = 1'b1; bus.line_data_i = mk_line(base);
      bus.line_offset_i = offs[t]; bus.inct_rready_i = 1'b1;
      #1; n_run++;
      if (bus.line_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL wrap_ready off=%0d: ready=%b want 1", offs[t], bus.line_ready_o);
      end
      for (int b = 0; b < 8; b++) begin
        @(negedge clk); bus.line_valid_i = 1'b0; #1;
        w = offs[t] + 3'(b); el = (b == 7);
        n_run++;
        if (bus.inct_rvalid_o !== 1'b1 || bus.inct_rdata_o !== wexp(base, w) || bus.inct_rlast_o !== el) begin
          n_fail++;
          $display("FAIL wrap off=%0d beat=%0d: rvalid=%b rdata=%h rlast=%b, want 1 %h %b",
                   offs[t], b, bus.inct_rvalid_o, bus.inct_rdata_o, bus.inct_rlast_o, wexp(base, w), el);
        end
      end
      @(negedge clk); #1; n_run++;
      if (bus.inct_rvalid_o !== 1'b0) begin
        n_fail++; $display("FAIL wrap_end off=%0d: rvalid=%b want 0", offs[t], bus.inct_rvalid_o);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] base;
    logic [2:0]  w;
    int b, cyc, stall_left;
    base = 64'h2222_0000_0000_0000;
    @(negedge clk);
    bus.line_valid_i = 1'b1; bus.line_data_i = mk_line(base);
    bus.line_offset_i = 3'd2; bus.inct_rready_i = 1'b1;
    b = 0; cyc = 0; stall_left = 3;
    while (b < 8 && cyc < 40) begin
      @(negedge clk); bus.line_valid_i = 1'b0;
      if (b == 3 && stall_left > 0) begin bus.inct_rready_i = 1'b0; stall_left--; end
      else bus.inct_rready_i = 1'b1;
      #1; cyc++;
      w = 3'd2 + 3'(b);
      n_run++;
      if (bus.inct_rvalid_o !== 1'b1 || bus.inct_rdata_o !== wexp(base, w) || bus.inct_rlast_o !== (b == 7)) begin
        n_fail++;
        $display("FAIL stall cyc=%0d beat=%0d: rvalid=%b rdata=%h rlast=%b, want 1 %h %b",
                 cyc, b, bus.inct_rvalid_o, bus.inct_rdata_o, bus.inct_rlast_o, wexp(base, w), (b == 7));
      end
      if (bus.inct_rready_i) b++;
    end
    n_run++;
    if (cyc !== 11) begin
      n_fail++; $display("FAIL stall_len: cycles=%0d want 11", cyc);
    end
    @(negedge clk); #1; n_run++;
    if (bus.inct_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_end: rvalid=%b want 0", bus.inct_rvalid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ba, bb;
    logic [2:0]  w;
    ba = 64'h1111_0000_0000_0000; bb = 64'h6666_0000_0000_0000;
    @(negedge clk);
    bus.line_valid_i = 1'b1; bus.line_data_i = mk_line(ba);
    bus.line_offset_i = 3'd0; bus.inct_rready_i = 1'b1;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (b == 7) begin
        bus.line_valid_i = 1'b1; bus.line_data_i = mk_line(bb); bus.line_offset_i = 3'd7;
      end else bus.line_valid_i = 1'b0;
      #1; w = 3'(b);
      n_run++;
      if (bus.inct_rvalid_o !== 1'b1 || bus.inct_rdata_o !== wexp(ba, w) || bus.line_ready_o !== (b == 7)) begin
        n_fail++;
        $display("FAIL b2b_first beat=%0d: rvalid=%b rdata=%h ready=%b, want 1 %h %b",
                 b, bus.inct_rvalid_o, bus.inct_rdata_o, bus.line_ready_o, wexp(ba, w), (b == 7));
      end
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk); bus.line_valid_i = 1'b0; #1;
      w = 3'd7 + 3'(b);
      n_run++;
      if (bus.inct_rvalid_o !== 1'b1 || bus.inct_rdata_o !== wexp(bb, w) || bus.inct_rlast_o !== (b == 7)) begin
        n_fail++;
        $display("FAIL b2b_second beat=%0d: rvalid=%b rdata=%h rlast=%b, want 1 %h %b",
                 b, bus.inct_rvalid_o, bus.inct_rdata_o, bus.inct_rlast_o, wexp(bb, w), (b == 7));
      end
    end
    @(negedge clk); #1; n_run++;
    if (bus.inct_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: rvalid=%b want 0", bus.inct_rvalid_o);
    end
  endtask

  task automatic test_midburst_load();
    logic [63:0] ba, bc, bd;
    logic [2:0]  w;
    ba = 64'h1111_0000_0000_0000; bc = 64'h3333_0000_0000_0000; bd = 64'hDEAD_0000_0000_0000;
    @(negedge clk);
    bus.line_valid_i = 1'b1; bus.line_data_i = mk_line(ba);
    bus.line_offset_i = 3'd1; bus.inct_rready_i = 1'b1;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (b >= 2) begin
        bus.line_valid_i = 1'b1;
        if (b < 6) begin bus.line_data_i = mk_line(bd); bus.line_offset_i = 3'd0; end
        else begin bus.line_data_i = mk_line(bc); bus.line_offset_i = 3'd3; end
      end else bus.line_valid_i = 1'b0;
      #1; w = 3'd1 + 3'(b);
      n_run++;
      if (bus.inct_rdata_o !== wexp(ba, w) || bus.line_ready_o !== (b == 7)) begin
        n_fail++;
        $display("FAIL mid_first beat=%0d: rdata=%h ready=%b, want %h %b",
                 b, bus.inct_rdata_o, bus.line_ready_o, wexp(ba, w), (b == 7));
      end
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk); bus.line_valid_i = 1'b0; bus.line_data_i = mk_line(bd); #1;
      w = 3'd3 + 3'(b);
      n_run++;
      if (bus.inct_rvalid_o !== 1'b1 || bus.inct_rdata_o !== wexp(bc, w) || bus.inct_rlast_o !== (b == 7)) begin
        n_fail++;
        $display("FAIL mid_second beat=%0d: rvalid=%b rdata=%h rlast=%b, want 1 %h %b",
                 b, bus.inct_rvalid_o, bus.inct_rdata_o, bus.inct_rlast_o, wexp(bc, w), (b == 7));
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_midburst();
    logic [63:0] be, bf;
    logic [2:0]  w;
    be = 64'h4444_0000_0000_0000; bf = 64'h5555_0000_0000_0000;
    @(negedge clk);
    bus.line_valid_i = 1'b1; bus.line_data_i = mk_line(be);
    bus.line_offset_i = 3'd0; bus.inct_rready_i = 1'b1;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk); bus.line_valid_i = 1'b0;
      if (b == 4) rst_n = 1'b0;
      #1; w = 3'(b);
      n_run++;
      if (bus.inct_rdata_o !== wexp(be, w)) begin
        n_fail++; $display("FAIL rstmid_pre beat=%0d: rdata=%h want %h", b, bus.inct_rdata_o, wexp(be, w));
      end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_run++;
    if (bus.inct_rvalid_o !== 1'b0 || bus.inct_rlast_o !== 1'b0 ||
        bus.line_ready_o !== 1'b1 || bus.inct_rdata_o !== 64'd0) begin
      n_fail++;
      $display("FAIL rstmid_post: rvalid=%b rlast=%b ready=%b rdata=%h, want 0 0 1 0",
               bus.inct_rvalid_o, bus.inct_rlast_o, bus.line_ready_o, bus.inct_rdata_o);
    end
    @(negedge clk);
    bus.line_valid_i = 1'b1; bus.line_data_i = mk_line(bf); bus.line_offset_i = 3'd6;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk); bus.line_valid_i = 1'b0; #1;
      w = 3'd6 + 3'(b);
      n_run++;
      if (bus.inct_rvalid_o !== 1'b1 || bus.inct_rdata_o !== wexp(bf, w) || bus.inct_rlast_o !== (b == 7)) begin
        n_fail++;
        $display("FAIL rstmid_fresh beat=%0d: rvalid=%b rdata=%h rlast=%b, want 1 %h %b",
                 b, bus.inct_rvalid_o, bus.inct_rdata_o, bus.inct_rlast_o, wexp(bf, w), (b == 7));
      end
    end
    @(negedge clk); #1; n_run++;
    if (bus.inct_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_end: rvalid=%b want 0", bus.inct_rvalid_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.line_valid_i  = 1'b0;
    bus.line_data_i   = '0;
    bus.line_offset_i = '0;
    bus.inct_rready_i = 1'b1;
    test_reset();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_midburst_load();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
